// File: rtl/pu_irq_sequencer_pkg.sv
// pu_irq_sequencer_pkg : shared types and helpers for the PU interrupt sequencer
// Revision 1.0
`default_nettype none

package pu_irq_sequencer_pkg;

  localparam int RETRY_W = 8;
  localparam int MAX_EXT = 16;

  typedef enum logic [1:0] {
    ST_AWAKE = 2'd0,
    ST_WAKE  = 2'd1,
    ST_WAIT  = 2'd2
  } wake_state_t;

  // Isolates the lowest set bit: v & -v
  function automatic logic [MAX_EXT-1:0] lowest_onehot(input logic [MAX_EXT-1:0] v);
    return v & (~v + MAX_EXT'(1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/pu_irq_wake_fsm.sv
// pu_irq_wake_fsm : wakes a sleeping PU, re-pulsing wakeup on timeout and counting retries
// Revision 1.0
`default_nettype none

module pu_irq_wake_fsm
  import pu_irq_sequencer_pkg::*;
#(
  parameter int WAKE_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sleep,
  input  logic               work,
  output logic               wakeup,
  output logic [RETRY_W-1:0] wake_retries
);

  localparam int TMR_W = $clog2(WAKE_TIMEOUT + 1);

  wake_state_t      state;
  wake_state_t      state_nxt;
  logic [TMR_W-1:0] timer;
  logic             load;
  logic             tick;
  logic             retry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_AWAKE;
      timer        <= '0;
      wake_retries <= '0;
    end else begin
      state <= state_nxt;
      if (load)
        timer <= TMR_W'(WAKE_TIMEOUT);
      else if (tick)
        timer <= timer - TMR_W'(1);
      if (retry && (wake_retries != '1))
        wake_retries <= wake_retries + RETRY_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    tick      = 1'b0;
    retry     = 1'b0;
    wakeup    = 1'b0;
    case (state)
      ST_AWAKE: begin
        if (sleep && work)
          state_nxt = ST_WAKE;
      end
      ST_WAKE: begin
        wakeup    = 1'b1;
        load      = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // The PU coming out of sleep takes priority over an expiring timer
        if (!sleep) begin
          state_nxt = ST_AWAKE;
        end else if (timer == '0) begin
          state_nxt = ST_WAKE;
          retry     = 1'b1;
        end else begin
          tick = 1'b1;
        end
      end
      default: state_nxt = ST_AWAKE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pu_irq_sequencer.sv
// pu_irq_sequencer : latches external interrupts, counts doorbells, drives PU request/wakeup lines
// Revision 1.0
`default_nettype none

module pu_irq_sequencer
  import pu_irq_sequencer_pkg::*;
#(
  parameter int NUM_EXT      = 4,
  parameter int DB_CNT_W     = 4,
  parameter int WAKE_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_EXT-1:0]  ext_src,
  input  logic [NUM_EXT-1:0]  ext_mask,
  input  logic                db_ring,
  input  logic                wake_req,
  input  logic                sleep,
  input  logic                doorbell_ack,
  input  logic                ext_input_ack,
  output logic                doorbell,
  output logic                ext_input,
  output logic                wakeup,
  output logic [NUM_EXT-1:0]  ext_pending,
  output logic [DB_CNT_W-1:0] db_count,
  output logic [RETRY_W-1:0]  wake_retries
);

  localparam logic [DB_CNT_W-1:0] DB_MAX = '1;

  logic [NUM_EXT-1:0] src_q;
  logic [NUM_EXT-1:0] rise;
  logic [NUM_EXT-1:0] clr;
  logic               ext_ack_fire;
  logic               db_inc;
  logic               db_dec;
  logic               work;

  assign rise         = ext_src & ~src_q & ~ext_mask;
  assign ext_ack_fire = ext_input_ack & ext_input;
  assign clr          = ext_ack_fire ? NUM_EXT'(lowest_onehot(MAX_EXT'(ext_pending))) : '0;
  assign db_dec       = doorbell_ack & doorbell;
  assign db_inc       = db_ring & (db_count != DB_MAX);
  assign work         = (ext_pending != '0) || (db_count != '0) || wake_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q       <= '0;
      ext_pending <= '0;
      ext_input   <= 1'b0;
      db_count    <= '0;
      doorbell    <= 1'b0;
    end else begin
      src_q       <= ext_src;
      // A fresh edge on the bit being retired re-latches it
      ext_pending <= (ext_pending & ~clr) | rise;
      ext_input   <= (ext_pending != '0) && !ext_ack_fire;
      // Ring and ack together leave the count alone, even when saturated
      if (db_inc && !db_dec)
        db_count <= db_count + DB_CNT_W'(1);
      else if (db_dec && !db_ring)
        db_count <= db_count - DB_CNT_W'(1);
      doorbell    <= (db_count != '0) && !db_dec;
    end
  end

  pu_irq_wake_fsm #(
    .WAKE_TIMEOUT (WAKE_TIMEOUT)
  ) u_wake_fsm (
    .clk          (clk),
    .reset        (reset),
    .sleep        (sleep),
    .work         (work),
    .wakeup       (wakeup),
    .wake_retries (wake_retries)
  );

endmodule

`default_nettype wire

// File: tb/tb_pu_irq_sequencer.sv
// tb_pu_irq_sequencer : directed vector table plus multi-cycle wake/saturation/reset sequences
// Revision 1.0
`default_nettype none

module tb_pu_irq_sequencer;

  localparam int NUM_EXT      = 4;
  localparam int DB_CNT_W     = 4;
  localparam int WAKE_TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [NUM_EXT-1:0]  ext_src = '0;
  logic [NUM_EXT-1:0]  ext_mask = '0;
  logic                db_ring = 1'b0;
  logic                wake_req = 1'b0;
  logic                sleep = 1'b0;
  logic                doorbell_ack = 1'b0;
  logic                ext_input_ack = 1'b0;
  logic                doorbell;
  logic                ext_input;
  logic                wakeup;
  logic [NUM_EXT-1:0]  ext_pending;
  logic [DB_CNT_W-1:0] db_count;
  logic [7:0]          wake_retries;

  always #5 clk = ~clk;

  pu_irq_sequencer #(
    .NUM_EXT      (NUM_EXT),
    .DB_CNT_W     (DB_CNT_W),
    .WAKE_TIMEOUT (WAKE_TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ext_src       (ext_src),
    .ext_mask      (ext_mask),
    .db_ring       (db_ring),
    .wake_req      (wake_req),
    .sleep         (sleep),
    .doorbell_ack  (doorbell_ack),
    .ext_input_ack (ext_input_ack),
    .doorbell      (doorbell),
    .ext_input     (ext_input),
    .wakeup        (wakeup),
    .ext_pending   (ext_pending),
    .db_count      (db_count),
    .wake_retries  (wake_retries)
  );

  typedef struct {
    logic [3:0] src;
    logic [3:0] mask;
    logic       ring;
    logic       ack_db;
    logic       ack_ext;
    logic [3:0] e_pend;
    logic       e_ei;
    logic [3:0] e_cnt;
    logic       e_db;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    db_ring       = 1'b0;
    wake_req      = 1'b0;
    doorbell_ack  = 1'b0;
    ext_input_ack = 1'b0;
  endtask

  task automatic add(input logic [3:0] s, input logic [3:0] m, input logic r, input logic adb,
                     input logic aex, input logic [3:0] ep, input logic eei,
                     input logic [3:0] ec, input logic edb);
    vec_t v;
    v.src = s; v.mask = m; v.ring = r; v.ack_db = adb; v.ack_ext = aex;
    v.e_pend = ep; v.e_ei = eei; v.e_cnt = ec; v.e_db = edb;
    vecs.push_back(v);
  endtask

  initial begin
    int pulses;
    int p [3];

    //   src      mask     rg  adb  aex  pend     ei  cnt  db
    add(4'b0000, 4'b0000, 0,  0,   0,   4'b0000, 0,  0,   0);
    add(4'b0100, 4'b0000, 0,  0,   0,   4'b0100, 0,  0,   0);
    add(4'b0100, 4'b0000, 0,  0,   0,   4'b0100, 1,  0,   0);
    add(4'b0100, 4'b0000, 0,  0,   1,   4'b0000, 0,  0,   0);
    add(4'b0100, 4'b0000, 0,  0,   0,   4'b0000, 0,  0,   0);
    add(4'b1101, 4'b0000, 0,  0,   0,   4'b1001, 0,  0,   0);
    add(4'b1101, 4'b0000, 0,  0,   0,   4'b1001, 1,  0,   0);
    add(4'b1101, 4'b0000, 0,  0,   1,   4'b1000, 0,  0,   0);
    add(4'b1101, 4'b0000, 0,  0,   1,   4'b1000, 1,  0,   0);
    add(4'b1101, 4'b0000, 0,  0,   1,   4'b0000, 0,  0,   0);
    add(4'b0000, 4'b0000, 0,  0,   0,   4'b0000, 0,  0,   0);
    add(4'b0001, 4'b0001, 0,  0,   0,   4'b0000, 0,  0,   0);
    add(4'b0010, 4'b0000, 0,  0,   0,   4'b0010, 0,  0,   0);
    add(4'b0010, 4'b0010, 0,  0,   0,   4'b0010, 1,  0,   0);
    add(4'b0000, 4'b0000, 0,  0,   0,   4'b0010, 1,  0,   0);
    add(4'b0010, 4'b0000, 0,  0,   1,   4'b0010, 0,  0,   0);
    add(4'b0010, 4'b0000, 0,  0,   1,   4'b0010, 1,  0,   0);
    add(4'b0010, 4'b0000, 0,  0,   1,   4'b0000, 0,  0,   0);
    add(4'b0000, 4'b0000, 0,  0,   0,   4'b0000, 0,  0,   0);
    add(4'b0000, 4'b0000, 1,  0,   0,   4'b0000, 0,  1,   0);
    add(4'b0000, 4'b0000, 0,  0,   0,   4'b0000, 0,  1,   1);
    add(4'b0000, 4'b0000, 1,  1,   0,   4'b0000, 0,  1,   0);
    add(4'b0000, 4'b0000, 0,  0,   0,   4'b0000, 0,  1,   1);
    add(4'b0000, 4'b0000, 0,  1,   0,   4'b0000, 0,  0,   0);
    add(4'b0000, 4'b0000, 0,  0,   0,   4'b0000, 0,  0,   0);
    add(4'b0000, 4'b0000, 0,  1,   0,   4'b0000, 0,  0,   0);

    // Reset state
    cyc();
    cyc();
    check("rst_doorbell", doorbell, 0);
    check("rst_ext_input", ext_input, 0);
    check("rst_wakeup", wakeup, 0);
    check("rst_ext_pending", ext_pending, 0);
    check("rst_db_count", db_count, 0);
    check("rst_wake_retries", wake_retries, 0);
    reset = 1'b1;

    // Vector table, awake PU
    foreach (vecs[i]) begin
      ext_src       = vecs[i].src;
      ext_mask      = vecs[i].mask;
      db_ring       = vecs[i].ring;
      doorbell_ack  = vecs[i].ack_db;
      ext_input_ack = vecs[i].ack_ext;
      cyc();
      check($sformatf("v%0d_ext_pending", i), ext_pending, vecs[i].e_pend);
      check($sformatf("v%0d_ext_input", i), ext_input, vecs[i].e_ei);
      check($sformatf("v%0d_db_count", i), db_count, vecs[i].e_cnt);
      check($sformatf("v%0d_doorbell", i), doorbell, vecs[i].e_db);
      check($sformatf("v%0d_wakeup", i), wakeup, 0);
    end
    clear_strobes();
    ext_src  = '0;
    ext_mask = '0;

    // Doorbell saturation, ring+ack at saturation, then drain
    db_ring = 1'b1;
    for (int i = 0; i < 17; i++) cyc();
    check("sat_db_count", db_count, 15);
    check("sat_doorbell", doorbell, 1);
    doorbell_ack = 1'b1;
    cyc();
    check("sat_ringack_count", db_count, 15);
    check("sat_ringack_gap", doorbell, 0);
    for (int i = 0; i < 15; i++) begin
      clear_strobes();
      cyc();
      check($sformatf("drain%0d_doorbell", i), doorbell, 1);
      doorbell_ack = 1'b1;
      cyc();
      check($sformatf("drain%0d_count", i), db_count, 14 - i);
    end
    clear_strobes();
    cyc();
    check("drain_final_doorbell", doorbell, 0);

    // Asleep PU, single ring wakes it; sleep drops during WAIT
    sleep   = 1'b1;
    db_ring = 1'b1;
    cyc();
    check("wk_first_wakeup", wakeup, 0);
    clear_strobes();
    cyc();
    check("wk_pulse", wakeup, 1);
    cyc();
    check("wk_pulse_end", wakeup, 0);
    cyc();
    sleep = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (wakeup) pulses++;
    end
    check("wk_no_more_pulses", pulses, 0);
    check("wk_retries", wake_retries, 0);
    doorbell_ack = 1'b1;
    cyc();
    clear_strobes();
    check("wk_db_retired", db_count, 0);

    // Retry cadence and retry counter saturation
    sleep    = 1'b1;
    wake_req = 1'b1;
    cyc();
    check("rt_first_pulse", wakeup, 1);
    wake_req = 1'b0;
    pulses   = 1;
    p[0]     = 1;
    p[1]     = 0;
    p[2]     = 0;
    for (int c = 2; c <= 4700; c++) begin
      cyc();
      if (wakeup) begin
        if (pulses < 3) p[pulses] = c;
        pulses++;
      end
      if (c == 40) check("rt_retries_after3", wake_retries, 2);
    end
    check("rt_pulse2_cycle", p[1], 19);
    check("rt_pulse3_cycle", p[2], 37);
    check("rt_pulse_total", pulses, 262);
    check("rt_retries_sat", wake_retries, 255);
    sleep = 1'b0;
    cyc();
    cyc();

    // Reset in WAIT with work outstanding
    db_ring = 1'b1;
    ext_src = 4'b0001;
    for (int i = 0; i < 5; i++) cyc();
    clear_strobes();
    sleep = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    check("pre_rst_db_count", db_count, 5);
    check("pre_rst_doorbell", doorbell, 1);
    check("pre_rst_ext_pending", ext_pending, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_doorbell", doorbell, 0);
    check("mid_rst_ext_input", ext_input, 0);
    check("mid_rst_wakeup", wakeup, 0);
    check("mid_rst_ext_pending", ext_pending, 0);
    check("mid_rst_db_count", db_count, 0);
    check("mid_rst_wake_retries", wake_retries, 0);
    ext_src = '0;
    cyc();
    reset  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      cyc();
      if (wakeup) pulses++;
    end
    check("post_rst_no_wakeup", pulses, 0);
    check("post_rst_db_count", db_count, 0);
    check("post_rst_doorbell", doorbell, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
